// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared widths, register constants and load-type codes
// Rev 1.0
// ============================================================================
package mips_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;

    localparam logic [NB_REG-1:0] REG_RA = 5'd31;

    // Load width/sign codes taken straight from opcode[2:0]
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b011,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_type_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } wb_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// load_formatter : byte/halfword lane extraction with sign or zero extension
// Rev 1.0
// ============================================================================
module load_formatter
    import mips_pkg::*;
(
    input  logic [NB_DATA-1:0] word_i,
    input  logic [1:0]         offset_i,
    input  logic [2:0]         type_i,
    output logic [NB_DATA-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        case (offset_i)
            2'd0:    byte_w = word_i[7:0];
            2'd1:    byte_w = word_i[15:8];
            2'd2:    byte_w = word_i[23:16];
            default: byte_w = word_i[31:24];
        endcase
        // Halfword lane follows offset[1] only; a misaligned offset[0] is ignored
        half_w = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (type_i)
            LD_LB:   data_o = {{24{byte_w[7]}}, byte_w};
            LD_LH:   data_o = {{16{half_w[15]}}, half_w};
            LD_LBU:  data_o = {24'd0, byte_w};
            LD_LHU:  data_o = {16'd0, half_w};
            default: data_o = word_i;
        endcase
    end

endmodule : load_formatter
`default_nettype wire

// File: rtl/stage_writeback.sv
`default_nettype none
// ============================================================================
// stage_writeback : MEM/WB register, load formatting, write-back select,
//                   stall-hold of the BRAM word and retired-instruction count
// Rev 1.0
// ============================================================================
module stage_writeback #(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_REG  = mips_pkg::NB_REG
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_ALU_res,
    input  logic [NB_REG-1:0]  i_addr_reg_dst,
    input  logic [NB_DATA-1:0] i_pc_to_reg,
    input  logic               is_select_addr_reg,
    input  logic               is_write_pc,
    input  logic               is_RegWrite,
    input  logic               is_MemtoReg,
    input  logic [2:0]         is_load_store_type,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_wb_addr,
    output logic               os_RegWrite,
    output logic [NB_DATA-1:0] o_retired
);

    import mips_pkg::*;

    logic [NB_DATA-1:0] alu_q;
    logic [NB_REG-1:0]  addr_q;
    logic [NB_DATA-1:0] pc_q;
    logic               sel_ra_q;
    logic               write_pc_q;
    logic               regwrite_q;
    logic               memtoreg_q;
    logic [2:0]         ld_type_q;
    logic               valid_q;

    wb_state_e          state_q, state_d;
    logic [NB_DATA-1:0] hold_q,  hold_d;
    logic [NB_DATA-1:0] retired_q, retired_d;

    logic [NB_DATA-1:0] mem_word_w;
    logic [NB_DATA-1:0] load_val_w;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            alu_q      <= '0;
            addr_q     <= '0;
            pc_q       <= '0;
            sel_ra_q   <= 1'b0;
            write_pc_q <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            ld_type_q  <= 3'd0;
            valid_q    <= 1'b0;
            state_q    <= ST_RUN;
            hold_q     <= '0;
            retired_q  <= '0;
        end else begin
            if (i_enable) begin
                alu_q      <= i_ALU_res;
                addr_q     <= i_addr_reg_dst;
                pc_q       <= i_pc_to_reg;
                sel_ra_q   <= is_select_addr_reg;
                write_pc_q <= is_write_pc;
                regwrite_q <= is_RegWrite;
                memtoreg_q <= is_MemtoReg;
                ld_type_q  <= is_load_store_type;
                valid_q    <= i_valid;
            end
            state_q   <= state_d;
            hold_q    <= hold_d;
            retired_q <= retired_d;
        end
    end

    // The BRAM word is only valid in the first cycle after the address; a
    // stall snapshots it so the formatted result stays put until release.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        mem_word_w = i_mem_data;
        case (state_q)
            ST_RUN: begin
                if (!i_enable) begin
                    hold_d  = i_mem_data;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                mem_word_w = hold_q;
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (i_enable && valid_q) begin
            retired_d = retired_q + 1'b1;
        end
    end

    load_formatter u_load_formatter (
        .word_i   (mem_word_w),
        .offset_i (alu_q[1:0]),
        .type_i   (ld_type_q),
        .data_o   (load_val_w)
    );

    always_comb begin
        if (write_pc_q) begin
            o_wb_data = pc_q;
        end else if (memtoreg_q) begin
            o_wb_data = load_val_w;
        end else begin
            o_wb_data = alu_q;
        end
        o_wb_addr   = sel_ra_q ? NB_REG'(REG_RA) : addr_q;
        os_RegWrite = regwrite_q && valid_q && (o_wb_addr != '0);
        o_retired   = retired_q;
    end

endmodule : stage_writeback
`default_nettype wire

// File: tb/tb_stage_writeback.sv
`default_nettype none
// ============================================================================
// tb_stage_writeback : directed + random stimulus against a transaction model
// Rev 1.0
// ============================================================================
module tb_stage_writeback;

    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, valid, sel, wpc, rw, m2r;
    logic [31:0] alu, pc, mem;
    logic [4:0]  addr;
    logic [2:0]  lst;

    logic [31:0] o_wb_data, o_retired;
    logic [4:0]  o_wb_addr;
    logic        os_RegWrite;

    stage_writeback dut (
        .clk                (clk),
        .i_rst_n            (rst_n),
        .i_enable           (en),
        .i_valid            (valid),
        .i_ALU_res          (alu),
        .i_addr_reg_dst     (addr),
        .i_pc_to_reg        (pc),
        .is_select_addr_reg (sel),
        .is_write_pc        (wpc),
        .is_RegWrite        (rw),
        .is_MemtoReg        (m2r),
        .is_load_store_type (lst),
        .i_mem_data         (mem),
        .o_wb_data          (o_wb_data),
        .o_wb_addr          (o_wb_addr),
        .os_RegWrite        (os_RegWrite),
        .o_retired          (o_retired)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently committing, the BRAM word it sees
    // (first cycle after it was accepted), and the retired count.
    logic        m_valid = 0, m_sel = 0, m_wpc = 0, m_rw = 0, m_m2r = 0;
    logic [31:0] m_alu = 0, m_pc = 0, m_word = 0, m_ret = 0;
    logic [4:0]  m_addr = 0;
    logic [2:0]  m_lst = 0;
    logic        m_fresh = 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] fmt(input logic [31:0] w, input int off, input logic [2:0] t);
        int          b;
        int          h;
        logic [31:0] r;
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (t)
            3'b000:  r = (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b001:  r = (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b100:  r = 32'(b);
            3'b101:  r = 32'(h);
            default: r = w;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_model();
        logic [31:0] ed;
        logic [4:0]  ea;
        if (m_fresh) begin
            m_word  = mem;
            m_fresh = 0;
        end
        ed = m_wpc ? m_pc : (m_m2r ? fmt(m_word, int'(m_alu % 4), m_lst) : m_alu);
        ea = m_sel ? 5'd31 : m_addr;
        chk("wb_data", o_wb_data, ed);
        chk("wb_addr", {27'd0, o_wb_addr}, {27'd0, ea});
        chk("regwrite", {31'd0, os_RegWrite}, {31'd0, m_rw && m_valid && (ea != 0)});
        chk("retired", o_retired, m_ret);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            {m_valid, m_sel, m_wpc, m_rw, m_m2r} = '0;
            m_alu = 0; m_pc = 0; m_addr = 0; m_lst = 0; m_ret = 0;
            m_fresh = 1;
        end else if (en) begin
            if (m_valid) m_ret = m_ret + 1;
            m_valid = valid; m_alu = alu; m_addr = addr; m_pc = pc;
            m_sel = sel; m_wpc = wpc; m_rw = rw; m_m2r = m2r; m_lst = lst;
            m_fresh = 1;
        end
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        tick();
    endtask

    task automatic step_k(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check_model();
        chk(tag, o_wb_data, exp);
        tick();
    endtask

    task automatic set_in(input logic v, input logic [31:0] a, input logic [4:0] d,
                          input logic [31:0] p, input logic s, input logic w,
                          input logic r, input logic m, input logic [2:0] t);
        en = 1; valid = v; alu = a; addr = d; pc = p;
        sel = s; wpc = w; rw = r; m2r = m; lst = t;
    endtask

    task automatic rand_in();
        set_in(1'($urandom), $urandom, 5'($urandom), $urandom, 1'($urandom),
               1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               3'($urandom_range(0, 7)));
        mem = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ld_code [6];
        int          ld_off  [6];
        logic [31:0] ld_exp  [6];
        string       ld_tag  [6];

        ld_code = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b011};
        ld_off  = '{1, 1, 3, 2, 2, 1};
        ld_exp  = '{32'h0000007F, 32'h0000007F, 32'hFFFFFF80,
                    32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        ld_tag  = '{"lb_off1", "lbu_off1", "lb_off3", "lh_off2", "lhu_off2", "lw"};

        // Reset with random inputs, including enable
        rand_in();
        rst_n = 0;
        tick();
        rand_in();
        rst_n = 0;
        @(negedge clk);
        check_model();
        chk("rst_data", o_wb_data, 32'd0);
        chk("rst_addr", {27'd0, o_wb_addr}, 32'd0);
        chk("rst_we", {31'd0, os_RegWrite}, 32'd0);
        chk("rst_ret", o_retired, 32'd0);
        tick();
        rst_n = 1;

        // Load formatting against the fixed word 0x80FF7F01
        mem = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            set_in(1, 32'h1000 + 32'(ld_off[i]), 5'(3 + i), $urandom, 0, 0, 1, 1, ld_code[i]);
            if (i == 0) step();
            else step_k(ld_tag[i-1], ld_exp[i-1]);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_k(ld_tag[5], ld_exp[5]);

        // JAL-style write of the return address to $31, then an ALU result
        set_in(1, $urandom, 5'd7, 32'h48, 1, 1, 1, 0, 3'b011);
        step();
        set_in(1, 32'h1234, 5'd9, $urandom, 0, 0, 1, 0, 3'b011);
        @(negedge clk);
        check_model();
        chk("jal_data", o_wb_data, 32'h48);
        chk("jal_addr", {27'd0, o_wb_addr}, 32'd31);
        tick();

        // Write to $0 is suppressed but still retires
        set_in(1, $urandom, 5'd0, $urandom, 0, 0, 1, 0, 3'b011);
        step_k("rtype", 32'h1234);
        set_in(0, $urandom, 5'd1, $urandom, 0, 0, 1, 0, 3'b011);
        @(negedge clk);
        check_model();
        chk("r0_we", {31'd0, os_RegWrite}, 32'd0);
        tick();
        step();

        // Three-cycle stall on a LW; BRAM output changes underneath
        set_in(1, 32'h200, 5'd4, $urandom, 0, 0, 1, 1, 3'b011);
        step();
        rand_in();
        en = 0;
        mem = 32'h11223344;
        step_k("stall_c1", 32'h11223344);
        mem = 32'hDEADBEEF;
        step_k("stall_c2", 32'h11223344);
        mem = $urandom;
        step_k("stall_c3", 32'h11223344);
        en = 1;
        mem = $urandom;
        step_k("stall_rel", 32'h11223344);

        // Random traffic: stalls, toggles, bubbles, occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_in();
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1;

        // Counter wrap: preload all-ones during a stall, then one commit
        set_in(1, $urandom, 5'd2, $urandom, 0, 0, 1, 0, 3'b011);
        step();
        en = 0;
        step();
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFFFFFF;
        set_in(0, $urandom, 5'd2, $urandom, 0, 0, 1, 0, 3'b011);
        @(negedge clk);
        check_model();
        chk("ret_max", o_retired, 32'hFFFFFFFF);
        tick();
        @(negedge clk);
        check_model();
        chk("ret_wrap", o_retired, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) step();
        chk("ret_bubbles", o_retired, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_stage_writeback
`default_nettype wire

// File: doc/stage_writeback.md
# stage_writeback

Final pipeline stage of the MIPS core. It registers the control and data outputs of the memory stage (the MEM/WB boundary) and formats load data from the data BRAM's registered read port: byte/halfword extraction and sign/zero extension. It also selects the write-back value and destination register and drives the register-file write port and the forwarding unit. It keeps a retired-instruction counter for the debug unit and holds its result stable across debug-unit stalls.

## Interface
- `NB_DATA`, 32, datapath width
- `NB_REG`, 5, register address width
- `clk`  in  1  system clock; all state on rising edge
- `i_rst_n`  in  1  synchronous active-low reset
- `i_enable`  in  1  pipeline advance (debug-unit step/run); 0 = stall
- `i_valid`  in  1  memory stage holds a real (non-bubble) instruction
- `i_ALU_res`  in  32  ALU result / effective address from memory stage
- `i_addr_reg_dst`  in  5  destination register from memory stage
- `i_pc_to_reg`  in  32  return address for JAL/JALR
- `is_select_addr_reg`  in  1  1 = destination forced to $31
- `is_write_pc`  in  1  1 = write-back value is `i_pc_to_reg`
- `is_RegWrite`  in  1  instruction writes register file
- `is_MemtoReg`  in  1  write-back value comes from memory
- `is_load_store_type`  in  3  load width/sign code (opcode[2:0])
- `i_mem_data`  in  32  BRAM read word, valid one cycle after address presented
- `o_wb_data`  out  32  value written to register file / forwarded
- `o_wb_addr`  out  5  destination register
- `os_RegWrite`  out  1  register-file write enable
- `o_retired`  out  32  count of committed valid instructions

## Operation
- MEM/WB register captures `i_ALU_res`, `i_addr_reg_dst`, `i_pc_to_reg`, all `is_*` flags, `i_valid` on each edge with `i_enable`=1; holds when `i_enable`=0.
- Load formatter: byte offset = latched ALU_res[1:0], little-endian lanes (offset 0 → bits 7:0). Codes: 000 LB (sign-ext byte), 001 LH (sign-ext half, lane = offset[1]), 011 LW, 100 LBU, 101 LHU (zero-ext). Any other code → full word. Misaligned halfword: offset[0] ignored.
- Write-back mux priority: `write_pc` → pc_to_reg; else `MemtoReg` → formatted load; else ALU_res.
- Destination: `select_addr_reg`=1 → 5'd31, else latched addr.
- `os_RegWrite` = latched RegWrite AND latched valid AND (`o_wb_addr` ≠ 0).
- Stall hold FSM, states RUN, HOLD:
  - RUN with `i_enable`=0: formatter uses live `i_mem_data`; the word is captured into the hold register; next state HOLD.
  - HOLD: formatter uses the hold register. `i_enable`=1 → RUN.
  - RUN with `i_enable`=1: stays RUN.
- Retired counter: +1 on each edge with `i_enable`=1 and latched valid=1, modulo 2^32 (wraps FFFFFFFF→0). Stalled cycles never count.

## Timing
- Reset (`i_rst_n`=0 at edge): all latched fields 0, FSM=RUN, hold reg 0, counter 0. Outputs afterwards: `o_wb_data`=0, `o_wb_addr`=0, `os_RegWrite`=0, `o_retired`=0. Reset overrides `i_enable`.
- Latency: inputs presented in cycle N appear on the outputs in cycle N+1, combinationally from the latch plus `i_mem_data` of cycle N+1. This aligns with the BRAM's one-cycle read.
- Outputs are constant through any stall length, including stalls of 1 cycle and back-to-back stall/enable toggles.
- Reset during HOLD: returns to RUN; held word discarded.
- Writes to $0: the address still appears on `o_wb_addr`, but the write enable is suppressed. The instruction still counts as retired.

## Structure
- Shared package `mips_pkg`: load-type codes (LB/LH/LW/LBU/LHU), `REG_RA`=31, `NB_DATA`, `NB_REG`.
- Sub-module `load_formatter` (combinational): word + offset + type → 32-bit extended value.
- Latch, hold FSM, mux and counter live in `stage_writeback`.

## Test plan
- Reset: assert `i_rst_n`=0 with random inputs → all outputs 0 on the following cycle.
- Loads: mem word 0x80FF7F01, offset 1:
  - LB → 0x0000007F
  - LBU → 0x0000007F
  - offset 3, LB → 0xFFFFFF80
  - offset 2, LH → 0xFFFF80FF
  - offset 2, LHU → 0x000080FF
  - LW → 0x80FF7F01
- Mux: `write_pc`=1, `select_addr_reg`=1, pc=0x48 → `o_wb_data`=0x48, `o_wb_addr`=31. ALU-only R-type with ALU_res=0x1234 → 0x1234.
- $0 suppression: RegWrite=1, addr=0 → `os_RegWrite`=0, `o_retired` increments.
- Stall: LW issued, `i_enable` low 3 cycles, `i_mem_data` changed to 0xDEADBEEF in cycle 2 → `o_wb_data` holds the original word; `o_retired` unchanged until enable returns.
- Counter: preload via 2^32−1 valid commits (or forced) → next commit gives 0. Bubbles (`i_valid`=0) never increment.
